snd_mixer_sd: RTL and testbench
===============================

// Module: snd_mixer_sd
// PURPOSE
//  Stereo audio mixer and 1-bit sigma-delta DAC driving the snd_l/snd_r pins.
//  Sums beeper, tape_out, tape_in and the four 8-bit Covox/Soundrive channels.
//  Applies a ramped soft-mute gain so pause and reset produce no click.
//  Emits one first-order sigma-delta bitstream per side at clk28.
// PARAMETERS
//  BEEPER_LVL   10'd128  amplitude added to both sides while beeper=1
//  TAPEOUT_LVL  10'd64   amplitude added to both sides while tape_out=1
//  TAPEIN_LVL   10'd32   amplitude added to both sides while synced tape_in=1
//  RAMP_SHIFT   12       gain moves one step every 2^RAMP_SHIFT clk28 cycles
// PORTS
//  clk28     in   1   28 MHz system clock
//  rst_n0    in   1   asynchronous active-low reset
//  beeper    in   1   port FE beeper bit, clk28 domain
//  tape_out  in   1   port FE MIC bit, clk28 domain
//  tape_in   in   1   raw tape input pin (asynchronous)
//  mute      in   1   1 = ramp gain down to 0 (pause); 0 = ramp up to full
//  sd_l0     in   8   Soundrive left channel A, unsigned
//  sd_l1     in   8   Soundrive left channel B, unsigned
//  sd_r0     in   8   Soundrive right channel A, unsigned
//  sd_r1     in   8   Soundrive right channel B, unsigned
//  gain_o    out  5   current gain 0..16, for debug
//  dac_l     out  1   left sigma-delta bitstream
//  dac_r     out  1   right sigma-delta bitstream
// BEHAVIOUR
//  Reset (async, rst_n0=0):
//   - all registers clear: tin sync, mix, scaled and acc = 0; gain = 0
//   - dac_l = dac_r = 0
//   - gain always ramps up from 0 after reset (pop-free power-up), even mid-operation
//  Stage 0, tape_in synchroniser:
//   - 2-flop synchroniser gives tin_s; the raw pin is never used combinationally
//  Stage 1, mix register (1 clk):
//   - mix_x = sd_x0 + sd_x1 + (beeper ? BEEPER_LVL : 0) + (tape_out ? TAPEOUT_LVL : 0)
//     + (tin_s ? TAPEIN_LVL : 0)
//   - 10-bit unsigned; defaults peak at 734, so no overflow
//   - a sum >1023 (possible only with non-default params) saturates to 1023, never wraps
//  Gain ramp:
//   - free-running RAMP_SHIFT-bit prescaler; its terminal count is the step strobe
//   - on a strobe: mute=0 and gain<16 -> gain+1; mute=1 and gain>0 -> gain-1;
//     otherwise gain holds
//   - mute toggling mid-ramp reverses direction at the next strobe, with no jump
//  Stage 2, scaling (1 clk):
//   - scaled_x = (mix_x * gain) >> 4, 10-bit
//   - gain=16 passes mix unchanged; gain=0 gives 0
//  Stage 3, sigma-delta (1 clk):
//   - acc_x (11 bit) <= {1'b0, acc_x[9:0]} + scaled_x; dac_x = acc_x[10], registered
//   - over any 1024 consecutive cycles at constant input S, the count of ones = S exactly
//     (accumulator wraps modulo 1024)
//   - latency from an input change to its first effect on the dac bit: 3 clk28
//  Left and right paths are identical and fully independent, with no shared rounding.
// TESTING
//  T1 idle:
//   - all inputs 0, mute=0, run 2^17 cycles
//   - dac_l=dac_r=0 throughout; gain_o reaches 16 after 16*4096 cycles
//  T2 full scale:
//   - gain=16, sd_l0=sd_l1=255, beeper=tape_out=1, tin_s=1
//   - count ones over 1024 cycles: exactly 734 on dac_l
//  T3 stereo independence:
//   - gain=16, sd_l0=200, other sd inputs 0, one-bit inputs 0
//   - 200 ones per 1024 cycles on dac_l; dac_r all 0
//  T4 mute ramp:
//   - from gain 16, assert mute
//   - gain_o decrements every 4096 cycles and reaches 0 after 65536
//   - deassert mute at gain=5: next strobe gives 6
//  T5 tape_in sync:
//   - toggle tape_in asynchronously, other inputs 0, gain=16
//   - mix_l changes by 32 within 3 clk of the edge; no metastable path to mix
//  T6 reset mid-operation:
//   - assert rst_n0 during T2
//   - dac_l=dac_r=0 and gain_o=0 immediately (async); after release, ramp restarts from 0

Source files
------------

// File: rtl/snd_mixer_sd.sv
// snd_mixer_sd: stereo beeper/tape/Soundrive mixer with soft-mute gain ramp and 1-bit sigma-delta DACs
module snd_mixer_sd #(
  parameter logic [9:0] BEEPER_LVL  = 10'd128,
  parameter logic [9:0] TAPEOUT_LVL = 10'd64,
  parameter logic [9:0] TAPEIN_LVL  = 10'd32,
  parameter int         RAMP_SHIFT  = 12
) (
  input  logic       clk28,
  input  logic       rst_n0,
  input  logic       beeper,
  input  logic       tape_out,
  input  logic       tape_in,
  input  logic       mute,
  input  logic [7:0] sd_l0,
  input  logic [7:0] sd_l1,
  input  logic [7:0] sd_r0,
  input  logic [7:0] sd_r1,
  output logic [4:0] gain_o,
  output logic       dac_l,
  output logic       dac_r
);
  logic                  r_tin_m, r_tin_s;
  logic [9:0]            r_mix_l, r_mix_r, r_sc_l, r_sc_r;
  logic [10:0]           r_acc_l, r_acc_r;
  logic [RAMP_SHIFT-1:0] r_pre;
  logic [4:0]            r_gain;
  logic [11:0]           w_com, w_sum_l, w_sum_r;
  logic [9:0]            w_mix_l, w_mix_r;
  logic [4:0]            w_gain_nx;
  logic                  w_strobe;
  always_comb begin
    w_com     = (beeper   ? {2'b0, BEEPER_LVL}  : 12'd0)
              + (tape_out ? {2'b0, TAPEOUT_LVL} : 12'd0)
              + (r_tin_s  ? {2'b0, TAPEIN_LVL}  : 12'd0);
    w_sum_l   = {4'b0, sd_l0} + {4'b0, sd_l1} + w_com;
    w_sum_r   = {4'b0, sd_r0} + {4'b0, sd_r1} + w_com;
    w_mix_l   = (w_sum_l > 12'd1023) ? 10'd1023 : w_sum_l[9:0];
    w_mix_r   = (w_sum_r > 12'd1023) ? 10'd1023 : w_sum_r[9:0];
    w_strobe  = &r_pre;
    w_gain_nx = !w_strobe                    ? r_gain :
                (!mute && r_gain < 5'd16)    ? r_gain + 5'd1 :
                (mute && r_gain != 5'd0)     ? r_gain - 5'd1 : r_gain;
  end
  // accumulator carry-out is the bitstream; lower 10 bits wrap modulo 1024
  always_ff @(posedge clk28 or negedge rst_n0)
    if (!rst_n0) begin
      r_tin_m <= 1'b0;
      r_tin_s <= 1'b0;
      r_mix_l <= '0;
      r_mix_r <= '0;
      r_sc_l  <= '0;
      r_sc_r  <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_pre   <= '0;
      r_gain  <= '0;
    end else begin
      r_tin_m <= tape_in;
      r_tin_s <= r_tin_m;
      r_mix_l <= w_mix_l;
      r_mix_r <= w_mix_r;
      r_sc_l  <= 10'(({4'b0, r_mix_l} * {9'b0, r_gain}) >> 4);
      r_sc_r  <= 10'(({4'b0, r_mix_r} * {9'b0, r_gain}) >> 4);
      r_acc_l <= {1'b0, r_acc_l[9:0]} + {1'b0, r_sc_l};
      r_acc_r <= {1'b0, r_acc_r[9:0]} + {1'b0, r_sc_r};
      r_pre   <= r_pre + RAMP_SHIFT'(1);
      r_gain  <= w_gain_nx;
    end
  assign gain_o = r_gain;
  assign dac_l  = r_acc_l[10];
  assign dac_r  = r_acc_r[10];
endmodule

// File: tb/tb_snd_mixer_sd.sv
// tb_snd_mixer_sd: vector table of mixes with ones-per-1024 scoreboard, cycle model of gain/dac, ramp and reset sequences
module tb_snd_mixer_sd;
  localparam int RS   = 6;
  localparam int STEP = 1 << RS;
  logic       clk28 = 0, rst_n0 = 1, beeper = 0, tape_out = 0, tape_in = 0, mute = 0;
  logic [7:0] sd_l0 = 0, sd_l1 = 0, sd_r0 = 0, sd_r1 = 0;
  logic [4:0] gain_o;
  logic       dac_l, dac_r;
  int         checks = 0, errors = 0, nprint = 0;
  bit         mon_en = 0;
  typedef struct {logic [7:0] l0, l1, r0, r1; logic b, to, ti; int el, er;} vec_t;
  typedef struct {int idx; int l; int r;} exp_t;
  vec_t v[9];
  exp_t sb[$];
  always #5 clk28 = ~clk28;
  snd_mixer_sd #(.RAMP_SHIFT(RS)) dut (
    .clk28(clk28), .rst_n0(rst_n0), .beeper(beeper), .tape_out(tape_out), .tape_in(tape_in),
    .mute(mute), .sd_l0(sd_l0), .sd_l1(sd_l1), .sd_r0(sd_r0), .sd_r1(sd_r1),
    .gain_o(gain_o), .dac_l(dac_l), .dac_r(dac_r));
  int m_t1, m_t2, m_mix_l, m_mix_r, m_sc_l, m_sc_r, m_al, m_ar, m_dl, m_dr, m_cnt, m_gain;
  function automatic int mixv(int a, int b, int t);
    int s;
    s = a + b + (beeper ? 128 : 0) + (tape_out ? 64 : 0) + (t != 0 ? 32 : 0);
    return s > 1023 ? 1023 : s;
  endfunction
  always @(posedge clk28 or negedge rst_n0)
    if (!rst_n0) begin
      m_t1 <= 0; m_t2 <= 0; m_mix_l <= 0; m_mix_r <= 0; m_sc_l <= 0; m_sc_r <= 0;
      m_al <= 0; m_ar <= 0; m_dl <= 0; m_dr <= 0; m_cnt <= 0; m_gain <= 0;
    end else begin
      m_t1    <= int'(tape_in);
      m_t2    <= m_t1;
      m_mix_l <= mixv(int'(sd_l0), int'(sd_l1), m_t2);
      m_mix_r <= mixv(int'(sd_r0), int'(sd_r1), m_t2);
      m_sc_l  <= (m_mix_l * m_gain) / 16;
      m_sc_r  <= (m_mix_r * m_gain) / 16;
      m_dl    <= (m_al + m_sc_l) >= 1024 ? 1 : 0;
      m_dr    <= (m_ar + m_sc_r) >= 1024 ? 1 : 0;
      m_al    <= (m_al + m_sc_l) % 1024;
      m_ar    <= (m_ar + m_sc_r) % 1024;
      m_cnt   <= (m_cnt + 1) % STEP;
      if (m_cnt == STEP - 1)
        m_gain <= (!mute && m_gain < 16) ? m_gain + 1 : (mute && m_gain > 0) ? m_gain - 1 : m_gain;
    end
  always @(negedge clk28)
    if (mon_en) begin
      checks++;
      if (int'(gain_o) != m_gain || int'(dac_l) != m_dl || int'(dac_r) != m_dr) begin
        errors++;
        if (nprint < 10)
          $display("FAIL model t=%0t gain=%0d want %0d dac_l=%0d want %0d dac_r=%0d want %0d",
                   $time, gain_o, m_gain, dac_l, m_dl, dac_r, m_dr);
        nprint++;
      end
    end
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic ones(int n, output int l, output int r);
    l = 0; r = 0;
    repeat (n) begin
      @(negedge clk28);
      l += int'(dac_l);
      r += int'(dac_r);
    end
  endtask
  task automatic wait_gain(int g, int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget && ok == 0; i++) begin
      @(negedge clk28);
      if (int'(gain_o) == g) ok = 1;
    end
  endtask
  task automatic drive(vec_t x);
    sd_l0 = x.l0; sd_l1 = x.l1; sd_r0 = x.r0; sd_r1 = x.r1;
    beeper = x.b; tape_out = x.to; tape_in = x.ti;
  endtask
  function automatic vec_t mk(int l0, int l1, int r0, int r1, int b, int to, int ti, int el, int er);
    vec_t x;
    x.l0 = 8'(l0); x.l1 = 8'(l1); x.r0 = 8'(r0); x.r1 = 8'(r1);
    x.b = 1'(b); x.to = 1'(to); x.ti = 1'(ti); x.el = el; x.er = er;
    return x;
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int l, r, ok;
    exp_t e;
    v[0] = mk(0,   0,   0,   0,   0, 0, 0, 0,   0);
    v[1] = mk(255, 255, 0,   0,   1, 1, 1, 734, 224);
    v[2] = mk(200, 0,   0,   0,   0, 0, 0, 200, 0);
    v[3] = mk(0,   0,   3,   77,  0, 0, 0, 0,   80);
    v[4] = mk(0,   0,   0,   0,   1, 0, 0, 128, 128);
    v[5] = mk(0,   0,   0,   0,   0, 1, 0, 64,  64);
    v[6] = mk(0,   0,   0,   0,   0, 0, 1, 32,  32);
    v[7] = mk(0,   1,   255, 255, 1, 0, 0, 129, 638);
    v[8] = mk(255, 255, 255, 255, 1, 1, 1, 734, 734);
    #2 rst_n0 = 0;
    #1;
    chk("reset_gain", int'(gain_o), 0);
    chk("reset_dac_l", int'(dac_l), 0);
    chk("reset_dac_r", int'(dac_r), 0);
    @(negedge clk28);
    rst_n0 = 1;
    mon_en = 1;
    ones(17 * STEP, l, r);
    chk("idle_ones_l", l, 0);
    chk("idle_ones_r", r, 0);
    chk("rampup_gain", int'(gain_o), 16);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk28);
      drive(v[i]);
      sb.push_back('{i, v[i].el, v[i].er});
      repeat (6) @(negedge clk28);
      ones(1024, l, r);
      e = sb.pop_front();
      chk($sformatf("vec%0d_ones_l", e.idx), l, e.l);
      chk($sformatf("vec%0d_ones_r", e.idx), r, e.r);
    end
    mute = 1;
    wait_gain(5, 16 * STEP, ok);
    chk("mute_reach5", ok, 1);
    mute = 0;
    ok = 0;
    for (int i = 0; i < 2 * STEP && ok == 0; i++) begin
      @(negedge clk28);
      if (int'(gain_o) != 5) ok = 1;
    end
    chk("unmute_changed", ok, 1);
    chk("unmute_gain6", int'(gain_o), 6);
    mute = 1;
    repeat (17 * STEP) @(negedge clk28);
    chk("mute_gain0", int'(gain_o), 0);
    ones(1024, l, r);
    chk("muted_ones_l", l, 0);
    chk("muted_ones_r", r, 0);
    mute = 0;
    repeat (17 * STEP) @(negedge clk28);
    chk("reramp_gain16", int'(gain_o), 16);
    drive(v[1]);
    repeat (8) @(negedge clk28);
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk28);
      if (dac_l) ok = 1;
    end
    chk("t6_dac_high", ok, 1);
    #2 rst_n0 = 0;
    #1;
    chk("t6_gain0", int'(gain_o), 0);
    chk("t6_dac_l0", int'(dac_l), 0);
    chk("t6_dac_r0", int'(dac_r), 0);
    @(negedge clk28);
    rst_n0 = 1;
    repeat (STEP - 1) @(negedge clk28);
    chk("t6_pre_step", int'(gain_o), 0);
    @(negedge clk28);
    chk("t6_first_step", int'(gain_o), 1);
    repeat (STEP) @(negedge clk28);
    chk("t6_second_step", int'(gain_o), 2);
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
